// File: rtl/mpp_sequencer.sv
// mpp_sequencer: program sequencer feeding the mpp core's instruction input.
// Holds a loadable program memory of 8-bit words. Starting at start_addr, it
// fetches one word, presents it for HOLD_CYCLES cycles, then moves on. A run
// ends on HALT_OP, at the last address, or on abort.
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   wr_en/addr/data    program memory write (accepted in IDLE and DONE only)
//   start, start_addr  begin a run (sampled in IDLE only)
//   abort              end a run early (FETCH/ISSUE only)
//   instr_out          word for mpp.instruction; NOP_OP when nothing is issued
//   instr_valid        instr_out carries a program word
//   busy, done         busy in FETCH/ISSUE; done is a one-cycle end pulse
//   pc, issued_cnt     current/next address; words issued in this/last run
module mpp_sequencer #(
  parameter int              PROG_DEPTH  = 16,
  parameter int              ADDR_W      = 4,
  parameter int              HOLD_CYCLES = 2,
  parameter logic [7:0]      HALT_OP     = 8'hFF,
  parameter logic [7:0]      NOP_OP      = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              abort,
  output logic [7:0]        instr_out,
  output logic              instr_valid,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W:0]   issued_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0]        HOLD_LAST = 4'(HOLD_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PROG_DEPTH - 1);

  logic [7:0]        mem [PROG_DEPTH];
  logic [1:0]        state, state_n;
  logic [7:0]        ir, ir_n;
  logic [3:0]        hold, hold_n;
  logic [ADDR_W-1:0] pc_n;
  logic [ADDR_W:0]   cnt_n;
  logic [7:0]        rd_word;

  assign rd_word = mem[pc];

  // Program memory is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en && (state == S_IDLE || state == S_DONE))
      mem[wr_addr] <= wr_data;
  end

  always_comb begin
    state_n = state;
    ir_n    = ir;
    hold_n  = hold;
    pc_n    = pc;
    cnt_n   = issued_cnt;
    case (state)
      S_IDLE: begin
        // abort wins over a simultaneous start
        if (start && !abort) begin
          pc_n    = start_addr;
          cnt_n   = '0;
          state_n = S_FETCH;
        end
      end
      S_FETCH: begin
        if (abort) begin
          state_n = S_DONE;
        end else begin
          ir_n    = rd_word;
          hold_n  = '0;
          state_n = (rd_word == HALT_OP) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (abort) begin
          // partially held word is not counted
          state_n = S_DONE;
        end else if (hold == HOLD_LAST) begin
          cnt_n = issued_cnt + (ADDR_W+1)'(1);
          if (pc == LAST_ADDR) begin
            state_n = S_DONE;
          end else begin
            pc_n    = pc + ADDR_W'(1);
            state_n = S_FETCH;
          end
        end else begin
          hold_n = hold + 4'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with
  // the state they describe without any input-to-output combinational path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      ir          <= NOP_OP;
      hold        <= '0;
      pc          <= '0;
      issued_cnt  <= '0;
      instr_out   <= NOP_OP;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      ir          <= ir_n;
      hold        <= hold_n;
      pc          <= pc_n;
      issued_cnt  <= cnt_n;
      instr_out   <= (state_n == S_ISSUE) ? ir_n : NOP_OP;
      instr_valid <= (state_n == S_ISSUE);
      busy        <= (state_n == S_FETCH) || (state_n == S_ISSUE);
      done        <= (state_n == S_DONE);
    end
  end

endmodule

// File: tb/tb_mpp_sequencer.sv
// Scoreboard bench for mpp_sequencer: stimulus pushes the expected word per
// ISSUE cycle and the expected end-of-run pc/count; a monitor pops and
// compares whenever the DUT presents a valid word or a done pulse.
module tb_mpp_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       start = 1'b0;
  logic [3:0] start_addr = '0;
  logic       abort = 1'b0;
  logic [7:0] instr_out;
  logic       instr_valid, busy, done;
  logic [3:0] pc;
  logic [4:0] issued_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] exp_q [$];
  logic [8:0] done_q [$];   // {pc, issued_cnt}

  mpp_sequencer dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .start_addr(start_addr), .abort(abort),
    .instr_out(instr_out), .instr_valid(instr_valid), .busy(busy), .done(done),
    .pc(pc), .issued_cnt(issued_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (instr_valid) begin
        if (exp_q.size() == 0) chk("unexpected_word", {24'd0, instr_out}, 32'hDEAD);
        else chk("instr_out", {24'd0, instr_out}, {24'd0, exp_q.pop_front()});
      end else begin
        chk("nop_when_invalid", {24'd0, instr_out}, 32'h00);
      end
      if (done) begin
        if (done_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else chk("done_pc_cnt", {23'd0, pc, issued_cnt}, {23'd0, done_q.pop_front()});
      end
      if (done && busy) chk("done_and_busy", 32'd1, 32'd0);
    end
  end

  task automatic write_word(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk); wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk); wr_en = 1'b0;
  endtask

  // Runs from sa, optionally aborting or writing mid-run; checks the number
  // of edges from the start edge until done is seen.
  task automatic go(input logic [3:0] sa, input int exp_edges, input int abort_at,
                    input bit mid_wr, input logic [3:0] exp_pc, input logic [4:0] exp_cnt);
    int k;
    done_q.push_back({exp_pc, exp_cnt});
    @(negedge clk); start = 1'b1; start_addr = sa;
    @(posedge clk);
    #1 start = 1'b0; wr_en = 1'b0;
    k = 0;
    forever begin
      @(posedge clk); k++;
      @(negedge clk);
      abort = (k == abort_at);
      if (mid_wr) begin
        wr_en = (k == 2); wr_addr = 4'd1; wr_data = 8'hAA;
      end
      if (done) break;
      if (k > 200) begin
        chk("run_timeout", 32'(k), 32'(exp_edges));
        break;
      end
    end
    abort = 1'b0; wr_en = 1'b0;
    if (k <= 200) chk("done_latency", 32'(k), 32'(exp_edges));
    @(negedge clk);
    chk("idle_after_done", {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    #12;
    chk("rst_instr_out", {24'd0, instr_out}, 32'h00);
    chk("rst_valid_busy_done", {29'd0, instr_valid, busy, done}, 32'd0);
    chk("rst_pc_cnt", {23'd0, pc, issued_cnt}, 32'd0);
    @(negedge clk); rst = 1'b0;

    write_word(4'd0, 8'h07);
    write_word(4'd1, 8'h12);
    write_word(4'd2, 8'hFF);
    write_word(4'd14, 8'h05);
    write_word(4'd15, 8'h06);

    // Asynchronous reset in the middle of a run
    @(negedge clk); start = 1'b1; start_addr = 4'd1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("async_rst_instr_out", {24'd0, instr_out}, 32'h00);
    chk("async_rst_pc", {28'd0, pc}, 32'd0);
    chk("async_rst_busy_valid", {30'd0, busy, instr_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Basic run ending on halt
    exp_q.push_back(8'h07); exp_q.push_back(8'h07);
    exp_q.push_back(8'h12); exp_q.push_back(8'h12);
    go(4'd0, 7, -1, 1'b0, 4'd2, 5'd2);

    // End of memory, no wrap
    exp_q.push_back(8'h05); exp_q.push_back(8'h05);
    exp_q.push_back(8'h06); exp_q.push_back(8'h06);
    go(4'd14, 6, -1, 1'b0, 4'd15, 5'd2);

    // Abort in the first ISSUE cycle of word 07
    exp_q.push_back(8'h07);
    go(4'd0, 2, 1, 1'b0, 4'd0, 5'd0);

    // start and abort together in IDLE
    @(negedge clk); start = 1'b1; abort = 1'b1; start_addr = 4'd0;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("start_abort_idle_busy", {31'd0, busy}, 32'd0);
    end

    // Write while busy is dropped: word 1 stays 12
    exp_q.push_back(8'h07); exp_q.push_back(8'h07);
    exp_q.push_back(8'h12); exp_q.push_back(8'h12);
    go(4'd0, 7, -1, 1'b1, 4'd2, 5'd2);

    // Write together with start in IDLE: new word is issued
    @(negedge clk); wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h33;
    exp_q.push_back(8'h33); exp_q.push_back(8'h33);
    exp_q.push_back(8'h12); exp_q.push_back(8'h12);
    go(4'd0, 7, -1, 1'b0, 4'd2, 5'd2);

    repeat (3) @(negedge clk);
    chk("words_left", 32'(exp_q.size()), 32'd0);
    chk("dones_left", 32'(done_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mpp_sequencer.md
# mpp_sequencer

Program sequencer for the `mpp` processor core. It holds a small loadable program memory of 8-bit instruction words and drives `mpp`'s `instruction` input one word at a time, each for a fixed number of cycles. It runs from a start address until it reaches a halt opcode, the end of memory, or an abort. It sits between the system/test controller and `mpp`, replacing hand-driven instruction stimulus.

## Interface
- `PROG_DEPTH`, 16: number of program words; must be a power of two.
- `ADDR_W`, 4: address width, log2(`PROG_DEPTH`).
- `HOLD_CYCLES`, 2: cycles each instruction is presented to `mpp`; range 1..15.
- `HALT_OP`, 8'hFF: opcode that ends the program; it is never issued.
- `NOP_OP`, 8'h00: value driven on `instr_out` whenever no instruction is issued.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `wr_en` in 1: program memory write strobe.
- `wr_addr` in `ADDR_W`: write address.
- `wr_data` in 8: write data.
- `start` in 1: begin execution at `start_addr`; sampled in IDLE only.
- `start_addr` in `ADDR_W`: first program address.
- `abort` in 1: stop execution immediately.
- `instr_out` out 8: connects to `mpp.instruction`.
- `instr_valid` out 1: high while `instr_out` carries a program word.
- `busy` out 1: high in FETCH and ISSUE.
- `done` out 1: one-cycle pulse at program end (halt, end of memory, or abort).
- `pc` out `ADDR_W`: address of the current or next word.
- `issued_cnt` out `ADDR_W+1`: number of words issued in the current or last run.

## Operation
- States: IDLE, FETCH, ISSUE, DONE.
- **IDLE:**
  - On `start`=1 and `abort`=0: set `pc` to `start_addr`, clear `issued_cnt`, go to FETCH.
  - Otherwise stay in IDLE.
- **FETCH:**
  - Synchronous memory read of `mem[pc]` into the instruction register.
  - Next state is ISSUE, unless the word read is `HALT_OP`, in which case go to DONE.
- **ISSUE:**
  - Drive the instruction register on `instr_out` with `instr_valid`=1.
  - A hold counter counts `HOLD_CYCLES` cycles.
  - On the last hold cycle, increment `issued_cnt`:
    - if `pc` = `PROG_DEPTH`-1, go to DONE (no wrap);
    - otherwise increment `pc` and go to FETCH.
- **DONE:**
  - `done`=1 for exactly one cycle, then go to IDLE.
  - `pc` and `issued_cnt` hold their final values until the next start.
- **Abort:**
  - `abort`=1 in FETCH or ISSUE forces DONE on the next edge.
  - The partially held instruction is not counted.
  - `abort` in IDLE or DONE has no effect.
- **Simultaneous events:**
  - `start` and `abort` together in IDLE: abort wins and the block stays in IDLE.
  - `start` while busy is ignored.
- **Writes:**
  - Accepted only in IDLE and DONE.
  - `wr_en` while busy is dropped; memory is unchanged.
  - A write and a `start` in the same IDLE cycle: the write completes, and a FETCH of that address reads the new data.
- **Outputs outside ISSUE:** `instr_out`=`NOP_OP` and `instr_valid`=0 in all states except ISSUE.
- **Reset:**
  - State goes to IDLE.
  - `pc`=0, `issued_cnt`=0, `instr_out`=`NOP_OP`, `instr_valid`=0, `busy`=0, `done`=0.
  - Memory contents are not reset.
  - Reset asserted mid-run takes effect immediately (asynchronous); no `done` pulse follows.

## Timing
- `start` sampled at edge E0. FETCH runs during E0→E1, and the memory word is registered at E1.
- First word appears on `instr_out` after E1 and is held for `HOLD_CYCLES` cycles.
- Each issued word costs `HOLD_CYCLES`+1 cycles: one FETCH plus the hold.
- Halt path: the edge that completes a FETCH of `HALT_OP` enters DONE. `done` is high for the next cycle, then IDLE.
- For N issued words ending at the last memory address, `done` is high in cycle N·(`HOLD_CYCLES`+1)+1 after E0.
- `busy` rises the cycle after E0 and falls when DONE is entered.
- `done` and `busy` are never high together.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset values:** assert `rst` asynchronously between edges -> all outputs take their reset values immediately (`instr_out`=00, `pc`=0, `busy`=0).
- **Basic run with halt:** load mem[0..2]=07,12,FF; start at 0; `HOLD_CYCLES`=2.
  - `instr_out`=07 for 2 cycles, NOP for 1 cycle, then 12 for 2 cycles.
  - `done` pulses, `issued_cnt`=2, `pc`=2; FF never appears on `instr_out`.
- **End of memory:** fill mem[14]=05, mem[15]=06; start at 14 -> 05 then 06 issued, `done` pulses, `pc`=15, `issued_cnt`=2, no wrap to 0.
- **Abort mid-hold:** assert `abort` in the first ISSUE cycle of word 07 -> DONE next edge, `issued_cnt`=0, `instr_out` returns to 00.
- **Simultaneous start and abort in IDLE:** raise both together -> block stays IDLE, `busy` stays 0, no `done` pulse.
- **Write while busy:** `wr_en` to address 1 with data AA during a run -> mem[1] is unchanged (re-run issues the original word). A write in IDLE together with `start` -> the new word is issued.
